// File: rtl/niosii_system_sysid_pkg.sv
// Shared types and constants for the sysid checker: FSM states, result codes,
// sysid word addresses and the ID/timestamp of the image this build was made for.
package niosii_system_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ID,
    ST_LAT_ID,
    ST_RD_TS,
    ST_LAT_TS,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ID      = 2'b01;
  localparam logic [1:0] ERR_TS      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'd0;
  localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'd1424220532;

endpackage

// File: rtl/niosii_system_avm_read_port.sv
// Single-word Avalon read helper: accept detect, READ_LATENCY data-valid pipeline, stall timeout.
// Pulses are combinational from the read strobe; stalls only advance the timeout counter.
module niosii_system_avm_read_port #(
  parameter int READ_LATENCY   = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic rd_active,
  input  logic avm_waitrequest,
  output logic accept,
  output logic data_vld,
  output logic timeout
);

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] stall_cnt;
  logic        stalled;

  assign stalled = rd_active & avm_waitrequest;
  assign accept  = rd_active & ~avm_waitrequest;
  // Abort on the stalled cycle that brings the count up to the limit.
  assign timeout = stalled & ((stall_cnt + 16'd1) == TO_LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (!stalled || timeout) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  generate
    if (READ_LATENCY == 0) begin : g_lat0
      assign data_vld = accept;
    end else if (READ_LATENCY == 1) begin : g_lat1
      logic vld_q;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) vld_q <= 1'b0;
        else          vld_q <= accept;
      end
      assign data_vld = vld_q;
    end else begin : g_latn
      logic [READ_LATENCY-1:0] vld_sr;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) vld_sr <= '0;
        else          vld_sr <= {vld_sr[READ_LATENCY-2:0], accept};
      end
      assign data_vld = vld_sr[READ_LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Reads sysid ID then timestamp, compares with the expected image, retries mismatches.
// Result 4 cycles after start on a zero-wait slave; waitrequest stalls each read up to TIMEOUT_CYCLES.
module niosii_system_sysid_checker
  import niosii_system_sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          RETRY_LIMIT        = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [31:0] id_value,
  output logic [31:0] timestamp_value,
  output logic [1:0]  error_code
);

  localparam logic [2:0] RETRY_MAX = 3'(RETRY_LIMIT);

  state_t      state, state_nxt;
  logic [2:0]  attempt, attempt_nxt;
  logic        pass_nxt;
  logic [1:0]  err_nxt;
  logic [31:0] id_nxt, ts_nxt;
  logic        accept, data_vld, timeout;

  niosii_system_avm_read_port #(
    .READ_LATENCY  (READ_LATENCY),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_read_port (
    .clock          (clock),
    .reset_n        (reset_n),
    .rd_active      (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .accept         (accept),
    .data_vld       (data_vld),
    .timeout        (timeout)
  );

  always_comb begin
    state_nxt   = state;
    attempt_nxt = attempt;
    pass_nxt    = pass;
    err_nxt     = error_code;
    id_nxt      = id_value;
    ts_nxt      = timestamp_value;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt   = ST_RD_ID;
          attempt_nxt = '0;
        end
      end
      ST_RD_ID: begin
        if (timeout) begin
          state_nxt = ST_DONE;
          pass_nxt  = 1'b0;
          err_nxt   = ERR_TIMEOUT;
        end else if (accept) begin
          state_nxt = (READ_LATENCY == 0) ? ST_RD_TS : ST_LAT_ID;
        end
      end
      ST_LAT_ID: begin
        if (data_vld) state_nxt = ST_RD_TS;
      end
      ST_RD_TS: begin
        if (timeout) begin
          state_nxt = ST_DONE;
          pass_nxt  = 1'b0;
          err_nxt   = ERR_TIMEOUT;
        end else if (accept) begin
          state_nxt = (READ_LATENCY == 0) ? ST_CHECK : ST_LAT_TS;
        end
      end
      ST_LAT_TS: begin
        if (data_vld) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (id_value == EXPECTED_ID && timestamp_value == EXPECTED_TIMESTAMP) begin
          state_nxt = ST_DONE;
          pass_nxt  = 1'b1;
          err_nxt   = ERR_OK;
        end else if (attempt < RETRY_MAX) begin
          state_nxt   = ST_RD_ID;
          attempt_nxt = attempt + 3'd1;
        end else begin
          state_nxt = ST_DONE;
          pass_nxt  = 1'b0;
          // A wrong ID means a wrong image; report that ahead of the timestamp.
          err_nxt   = (id_value != EXPECTED_ID) ? ERR_ID : ERR_TS;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_nxt   = ST_RD_ID;
          attempt_nxt = '0;
          pass_nxt    = 1'b0;
          err_nxt     = ERR_OK;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (data_vld && (state == ST_RD_ID || state == ST_LAT_ID)) id_nxt = avm_readdata;
    if (data_vld && (state == ST_RD_TS || state == ST_LAT_TS)) ts_nxt = avm_readdata;
  end

  // Bus strobes and status are registered from the next state so every output is a flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      attempt         <= '0;
      pass            <= 1'b0;
      error_code      <= ERR_OK;
      id_value        <= '0;
      timestamp_value <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      avm_read        <= 1'b0;
      avm_address     <= SYSID_ADDR_ID;
    end else begin
      state           <= state_nxt;
      attempt         <= attempt_nxt;
      pass            <= pass_nxt;
      error_code      <= err_nxt;
      id_value        <= id_nxt;
      timestamp_value <= ts_nxt;
      busy            <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
      done            <= (state_nxt == ST_DONE);
      avm_read        <= (state_nxt == ST_RD_ID) || (state_nxt == ST_RD_TS);
      avm_address     <= (state_nxt == ST_RD_TS) ? SYSID_ADDR_TS : SYSID_ADDR_ID;
    end
  end

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Bench: two checkers (read latency 0 and 2) against planned sysid slaves and a timing/result model.
module tb_niosii_system_sysid_checker;

  localparam int          TO     = 8;
  localparam int          RL     = 3;
  localparam logic [31:0] EXP_ID = 32'd0;
  localparam logic [31:0] EXP_TS = 32'd1424220532;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  // Per-scenario slave plan: words served and stall cycles for each attempt/address.
  int          stall_p[4][2];
  logic [31:0] id_p[4];
  logic [31:0] ts_p[4];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h, expected %0h (cycle %0d)", nm, inst, act, exp, cyc);
    end
  endtask

  // Cycles from the start cycle until done is first seen, plus the final verdict.
  function automatic void model_run(input int lat, output int t, output logic ps, output logic [1:0] er);
    t = 1; ps = 1'b0; er = 2'b00;
    for (int a = 0; a <= RL; a++) begin
      for (int w = 0; w < 2; w++) begin
        if (stall_p[a][w] >= TO) begin
          t += TO; er = 2'b11;
          return;
        end
        t += stall_p[a][w] + 1 + lat;
      end
      t += 1;
      if (id_p[a] == EXP_ID && ts_p[a] == EXP_TS) begin
        ps = 1'b1;
        return;
      end
      if (a == RL) er = (id_p[a] != EXP_ID) ? 2'b01 : 2'b10;
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int LAT = g * 2;
    logic        busy, done, pass, rd, adr;
    logic        wr = 1'b0;
    logic [1:0]  err;
    logic [31:0] rdata = 32'd0;
    logic [31:0] idv, tsv;
    int          n0 = 0, t_run = 0, att = 0, stalled = 0, n_id_acc = 0;
    bit          have_run = 1'b0, nxt_addr = 1'b0;
    logic        exp_pass = 1'b0;
    logic [1:0]  exp_err = 2'b00;
    logic [31:0] exp_id = 32'd0, exp_ts = 32'd0;
    int          due_q[$];
    bit          adr_q[$];
    logic [31:0] dat_q[$];

    niosii_system_sysid_checker #(
      .READ_LATENCY(LAT), .TIMEOUT_CYCLES(TO), .RETRY_LIMIT(RL)
    ) dut (
      .clock(clock), .reset_n(reset_n), .start(start),
      .avm_address(adr), .avm_read(rd), .avm_waitrequest(wr), .avm_readdata(rdata),
      .busy(busy), .done(done), .pass(pass),
      .id_value(idv), .timestamp_value(tsv), .error_code(err)
    );

    always @(negedge clock) begin : model
      bit busy_e, done_e;
      int a;
      logic [31:0] d;
      if (!reset_n) begin
        have_run = 1'b0; exp_id = '0; exp_ts = '0; exp_pass = 1'b0; exp_err = '0;
        due_q.delete(); adr_q.delete(); dat_q.delete();
        wr = 1'b0;
        chk("rst_busy", g, busy, 0);
        chk("rst_done", g, done, 0);
        chk("rst_read", g, rd, 0);
      end else begin
        busy_e = have_run && cyc > n0 && cyc < n0 + t_run;
        done_e = have_run && cyc >= n0 + t_run;
        chk("busy", g, busy, busy_e);
        chk("done", g, done, done_e);
        chk("pass", g, pass, done_e ? exp_pass : 1'b0);
        chk("error_code", g, err, done_e ? exp_err : 2'b00);
        chk("id_value", g, idv, exp_id);
        chk("timestamp_value", g, tsv, exp_ts);
        if (!busy_e) chk("read_idle", g, rd, 0);

        if (start && !busy_e) begin
          n0 = cyc;
          model_run(LAT, t_run, exp_pass, exp_err);
          have_run = 1'b1; att = 0; stalled = 0; nxt_addr = 1'b0; n_id_acc = 0;
          due_q.delete(); adr_q.delete(); dat_q.delete();
        end

        // Slave: random idle waitrequest and garbage data except in the one valid cycle.
        wr = 1'($urandom);
        rdata = $urandom;
        if (rd) begin
          chk("address", g, adr, nxt_addr);
          a = (att > RL) ? RL : att;
          if (stalled < stall_p[a][adr]) begin
            wr = 1'b1;
            stalled++;
          end else begin
            wr = 1'b0;
            stalled = 0;
            d = adr ? ts_p[a] : id_p[a];
            if (!adr) n_id_acc++;
            if (LAT == 0) begin
              rdata = d;
              if (adr) exp_ts = d; else exp_id = d;
            end else begin
              due_q.push_back(cyc + LAT); adr_q.push_back(adr); dat_q.push_back(d);
            end
            nxt_addr = !nxt_addr;
            if (adr) att++;
          end
        end
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          rdata = dat_q[0];
          if (adr_q[0]) exp_ts = dat_q[0]; else exp_id = dat_q[0];
          void'(due_q.pop_front()); void'(adr_q.pop_front()); void'(dat_q.pop_front());
        end
      end
    end
  end

  task automatic plan_good();
    for (int a = 0; a < 4; a++) begin
      id_p[a] = EXP_ID; ts_p[a] = EXP_TS;
      stall_p[a][0] = 0; stall_p[a][1] = 0;
    end
  endtask

  // Start pulse in cycle n; optional second pulse at n+2 while both checkers are busy.
  task automatic kick(input bit extra, output int n);
    @(posedge clock); #1 start = 1'b1; n = cyc;
    @(posedge clock); #1 start = 1'b0;
    if (extra) begin
      @(posedge clock); #1 start = 1'b1;
      @(posedge clock); #1 start = 1'b0;
    end
  endtask

  task automatic wait_done(output int d0, output int d1);
    d0 = -1; d1 = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      if (g_inst[0].done && d0 < 0) d0 = cyc;
      if (g_inst[1].done && d1 < 0) d1 = cyc;
      if (d0 >= 0 && d1 >= 0) break;
    end
    if (d0 < 0 || d1 < 0) chk("done_wait", 0, 0, 1);
    @(negedge clock);
  endtask

  initial begin
    int n, d0, d1;
    plan_good();
    repeat (3) @(posedge clock);
    #1;
    chk("reset_done", 0, g_inst[0].done, 0);
    chk("reset_err", 0, g_inst[0].err, 0);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);

    // Zero-wait match: done four cycles after start (eight with latency 2).
    kick(0, n); wait_done(d0, d1);
    chk("lat0_cycles", 0, d0 - n, 4);
    chk("lat2_cycles", 1, d1 - n, 8);
    chk("s1_pass", 0, g_inst[0].pass, 1);
    chk("s1_ts", 1, g_inst[1].tsv, 32'd1424220532);

    // Five stall cycles on the ID read.
    stall_p[0][0] = 5;
    kick(0, n); wait_done(d0, d1);
    chk("stall_cycles", 0, d0 - n, 9);
    chk("stall_pass", 1, g_inst[1].pass, 1);

    // Timestamp always wrong: four sequences then error 10.
    plan_good();
    for (int a = 0; a < 4; a++) ts_p[a] = 32'h12345678;
    kick(1, n); wait_done(d0, d1);
    chk("ts_err", 0, g_inst[0].err, 2'b10);
    chk("ts_value", 0, g_inst[0].tsv, 32'h12345678);
    chk("ts_attempts", 0, g_inst[0].n_id_acc, 4);
    chk("ts_attempts", 1, g_inst[1].n_id_acc, 4);

    // Both words wrong: ID reported first.
    for (int a = 0; a < 4; a++) id_p[a] = 32'hDEAD0001;
    kick(0, n); wait_done(d0, d1);
    chk("id_err", 1, g_inst[1].err, 2'b01);

    // Two bad attempts then a good one.
    plan_good();
    id_p[0] = 32'h1; ts_p[1] = 32'h2;
    kick(0, n); wait_done(d0, d1);
    chk("retry_pass", 0, g_inst[0].pass, 1);
    chk("retry_attempts", 1, g_inst[1].n_id_acc, 3);

    // Waitrequest stuck on the ID read: abort after eight stalls, no retry.
    plan_good();
    stall_p[0][0] = 1000;
    kick(0, n); wait_done(d0, d1);
    chk("to_err", 0, g_inst[0].err, 2'b11);
    chk("to_cycles", 0, d0 - n, 9);
    chk("to_no_accept", 1, g_inst[1].n_id_acc, 0);
    repeat (3) @(negedge clock);
    chk("to_read_low", 0, g_inst[0].rd, 0);

    // Reset in the middle of the timestamp read, then restart with a busy-time start.
    plan_good();
    kick(0, n);
    @(posedge clock); #1;
    chk("pre_rst_read", 0, g_inst[0].rd, 1);
    chk("pre_rst_addr", 0, g_inst[0].adr, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rz_read", 0, g_inst[0].rd, 0);
    chk("rz_addr", 0, g_inst[0].adr, 0);
    chk("rz_busy", 0, g_inst[0].busy, 0);
    chk("rz_id", 0, g_inst[0].idv, 0);
    chk("rz_read", 1, g_inst[1].rd, 0);
    chk("rz_busy", 1, g_inst[1].busy, 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    kick(1, n); wait_done(d0, d1);
    chk("post_rst_pass", 0, g_inst[0].pass, 1);
    chk("post_rst_cycles", 1, d1 - n, 8);

    // Randomized plans with occasional timeouts and busy-time starts.
    for (int r = 0; r < 30; r++) begin
      for (int a = 0; a < 4; a++) begin
        id_p[a] = ($urandom_range(0, 3) == 0) ? $urandom : EXP_ID;
        ts_p[a] = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
        for (int w = 0; w < 2; w++)
          stall_p[a][w] = ($urandom_range(0, 15) == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, 3);
      end
      kick(1'($urandom), n);
      wait_done(d0, d1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles", cyc);
    $fatal(1);
  end

endmodule
